// File: rtl/cdm_mult_pipe.sv
// Three-stage valid/ready pipelined unsigned multiplier with an optional
// carry-disregard mode for the low K product columns.
`timescale 1ns/1ps
module cdm_mult_pipe #(
    parameter int unsigned W    = 16,
    parameter int unsigned K    = 8,
    parameter int unsigned TAGW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic              in_mode,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_r,
    output logic              out_mode,
    output logic [TAGW-1:0]   out_tag
);
    localparam int unsigned PW = 2 * W;

    logic              v1, v2, v3;
    logic              ld1, ld2, ld3;
    logic [W-1:0]      a1, b1;
    logic              m1, m2;
    logic [TAGW-1:0]   t1, t2;
    logic [PW-1:0]     hi2, lo2, lx2;
    logic [PW-1:0]     hi_n, lo_n, lx_n;

    always_comb begin
        ld3      = !v3 || out_ready;
        ld2      = !v2 || ld3;
        ld1      = !v1 || ld2;
        in_ready = ld1;
    end

    assign out_valid = v3;

    // hi: columns >= K summed with carries; lo: OR per low column;
    // lx: true sum of the low columns so the exact product is hi + lx.
    always_comb begin
        hi_n = '0;
        lo_n = '0;
        lx_n = '0;
        for (int unsigned i = 0; i < W; i++) begin
            for (int unsigned j = 0; j < W; j++) begin
                if (a1[i] & b1[j]) begin
                    if (i + j >= K) begin
                        hi_n = hi_n + (PW'(1) << (i + j));
                    end else begin
                        lx_n = lx_n + (PW'(1) << (i + j));
                        lo_n = lo_n | (PW'(1) << (i + j));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            a1       <= '0;
            b1       <= '0;
            m1       <= 1'b0;
            t1       <= '0;
            hi2      <= '0;
            lo2      <= '0;
            lx2      <= '0;
            m2       <= 1'b0;
            t2       <= '0;
            out_r    <= '0;
            out_mode <= 1'b0;
            out_tag  <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    a1 <= in_a;
                    b1 <= in_b;
                    m1 <= in_mode;
                    t1 <= in_tag;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    hi2 <= hi_n;
                    lo2 <= lo_n;
                    lx2 <= lx_n;
                    m2  <= m1;
                    t2  <= t1;
                end
            end
            // Output registers only change on a real load, so they hold under stall and when empty.
            if (ld3) begin
                v3 <= v2;
                if (v2) begin
                    out_r    <= m2 ? (hi2 + lo2) : (hi2 + lx2);
                    out_mode <= m2;
                    out_tag  <= t2;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdm_mult_pipe.sv
// Scoreboard bench for cdm_mult_pipe (W=16, K=8): directed vectors, latency,
// throughput, backpressure and asynchronous reset mid-stream.
`timescale 1ns/1ps
module tb_cdm_mult_pipe;
    localparam int unsigned W = 16;
    localparam int unsigned K = 8;
    localparam int unsigned TAGW = 4;

    typedef struct packed {
        logic [31:0] r;
        logic        m;
        logic [3:0]  t;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [15:0]     in_a = '0;
    logic [15:0]     in_b = '0;
    logic            in_mode = 1'b0;
    logic [3:0]      in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [31:0]     out_r;
    logic            out_mode;
    logic [3:0]      out_tag;

    int              tests = 0;
    int              fails = 0;
    int              n_out = 0;
    int              rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    exp_t            sb[$];

    cdm_mult_pipe #(.W(W), .K(K), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_mode(out_mode), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else               out_ready = (rdy_mode == 1);
    end

    // Column-count formulation: replace each low column's count*2^c by a single 2^c if non-zero.
    function automatic logic [31:0] ref_model(input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [31:0] p;
        int unsigned cnt;
        p = 32'(a) * 32'(b);
        if (m) begin
            for (int unsigned c = 0; c < K; c++) begin
                cnt = 0;
                for (int unsigned i = 0; i <= c; i++)
                    if (i < W && (c - i) < W && a[i] && b[c - i]) cnt++;
                p = p - (cnt << c);
                if (cnt != 0) p = p + (32'd1 << c);
            end
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready) begin
            exp_t e;
            n_out++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got r=%0h mode=%0b tag=%0h with nothing outstanding",
                         out_r, out_mode, out_tag);
            end else begin
                e = sb.pop_front();
                if ({out_r, out_mode, out_tag} !== e) begin
                    fails++;
                    $display("FAIL result: got r=%0h mode=%0b tag=%0h expected r=%0h mode=%0b tag=%0h",
                             out_r, out_mode, out_tag, e.r, e.m, e.t);
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m,
                        input logic [3:0] t, input logic [31:0] r);
        exp_t e;
        bit ok;
        in_a = a; in_b = b; in_mode = m; in_tag = t; in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got in_ready=0 for tag %0h expected 1", t);
        end else begin
            e.r = r; e.m = m; e.t = t;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        logic [31:0] held_r;
        logic [3:0]  held_t;
        logic [15:0] ra, rb;
        logic        rm;

        vecs.push_back('{16'h00FF, 16'h00FF, 1'b1, 32'h0000F7FF});
        vecs.push_back('{16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01});
        vecs.push_back('{16'h0003, 16'h0003, 1'b1, 32'h00000007});
        vecs.push_back('{16'h0003, 16'h0003, 1'b0, 32'h00000009});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 32'h0000FFFF});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF});
        vecs.push_back('{16'h0000, 16'h1234, 1'b1, 32'h00000000});
        vecs.push_back('{16'hABCD, 16'h0000, 1'b0, 32'h00000000});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
        vecs.push_back('{16'h0100, 16'h0002, 1'b1, 32'h00000200});
        vecs.push_back('{16'h0001, 16'h0001, 1'b1, 32'h00000001});

        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_r", 64'(out_r), 64'd0);
        chk("reset_out_mode_tag", 64'({out_mode, out_tag}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed vectors with hand-computed results, back to back.
        for (int i = 0; i < vecs.size(); i++)
            send(vecs[i].a, vecs[i].b, vecs[i].m, 4'(i), vecs[i].r);
        idle(5);
        chk("directed_drained", 64'(sb.size()), 64'd0);

        // Latency from an empty pipe: accept edge counts as the first of three.
        begin
            exp_t e;
            in_a = 16'h0003; in_b = 16'h0005; in_mode = 1'b0; in_tag = 4'hA; in_valid = 1'b1;
            e.r = 32'd15; e.m = 1'b0; e.t = 4'hA;
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
            chk("latency_edges", 64'(n), 64'd3);
            idle(3);
        end

        // Throughput: tags 0..15 one per cycle, all must be out 3 edges after the last accept.
        base = n_out;
        for (int t = 0; t < 16; t++) begin
            ra = 16'(t * 16'h1111);
            rb = 16'(16'h00F0 + t);
            rm = 1'(t & 1);
            send(ra, rb, rm, 4'(t), ref_model(ra, rb, rm));
        end
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("throughput_count", 64'(n_out - base), 64'd16);
        idle(3);

        // Backpressure: three fill the pipe, fourth must be refused and output held.
        rdy_mode = 0;
        @(posedge clk); #2;
        send(16'h0011, 16'h0022, 1'b0, 4'd1, 32'h00000242);
        send(16'h00FF, 16'h00FF, 1'b1, 4'd2, 32'h0000F7FF);
        send(16'h0003, 16'h0003, 1'b1, 4'd3, 32'h00000007);
        in_a = 16'h0007; in_b = 16'h0009; in_mode = 1'b0; in_tag = 4'd4; in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        held_r = out_r;
        held_t = out_tag;
        chk("stall_head_tag", 64'(held_t), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("stall_stable", 64'({out_r, out_tag}), 64'({held_r, held_t}));
        end
        rdy_mode = 1;
        @(posedge clk); #2;
        send(16'h0007, 16'h0009, 1'b0, 4'd4, 32'h0000003F);
        idle(6);
        chk("backpressure_drained", 64'(sb.size()), 64'd0);

        // Reset mid-stream: discard in-flight work, then a fresh input at normal latency.
        send(16'h0005, 16'h0005, 1'b0, 4'd5, 32'd25);
        send(16'h0006, 16'h0006, 1'b0, 4'd6, 32'd36);
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        @(negedge clk) rst = 1'b0;
        base = n_out;
        idle(6);
        chk("no_output_after_reset", 64'(n_out - base), 64'd0);
        begin
            exp_t e;
            in_a = 16'h00FF; in_b = 16'h00FF; in_mode = 1'b1; in_tag = 4'hC; in_valid = 1'b1;
            e.r = 32'h0000F7FF; e.m = 1'b1; e.t = 4'hC;
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
            chk("latency_after_reset", 64'(n), 64'd3);
            idle(3);
        end

        // Random operands and modes against the column model, with random output stalls.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 5 == 0) ra = ra & 16'h00FF;
            rm = 1'($urandom_range(0, 1));
            send(ra, rb, rm, 4'(i), ref_model(ra, rb, rm));
        end
        in_valid = 1'b0;
        rdy_mode = 1;
        idle(10);
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
